// File: rtl/wb_fifo_scheduler_pkg.sv
// Shared definitions for the write-back FIFO scheduler: FSM encoding,
// default geometry and a channel-index width helper.
package wb_fifo_scheduler_pkg;

  localparam int ROW_LEN_DEF = 61;
  localparam int DATA_W_DEF  = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // Channel index width, kept at least one bit so single-channel builds still elaborate.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// pointer; the pointer moves past the granted channel when a read is issued.
module wb_rr_arbiter
  import wb_fifo_scheduler_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = ch_bits(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          issue,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr;

  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/wb_fifo_scheduler.sv
// Drains N_CH conv-output FIFOs round-robin into a single write-back stream,
// tagging each word with its channel and per-channel frame index.
module wb_fifo_scheduler
  import wb_fifo_scheduler_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ROW_LEN = ROW_LEN_DEF,
  parameter  int FRM_W   = 16,
  localparam int CH_W    = ch_bits(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FRM_W-1:0]         frame_words,
  input  logic [N_CH-1:0]          fifo_empty,
  output logic [N_CH-1:0]          fifo_rd_en,
  input  logic [N_CH*DATA_W-1:0]   fifo_dout,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CH_W-1:0]          wb_ch,
  output logic [FRM_W-1:0]         wb_idx,
  output logic                     row_done,
  output logic                     busy,
  output logic                     done
);

  sched_state_t state, state_nxt;

  logic [FRM_W-1:0]  frm_words_q;
  logic [FRM_W-1:0]  issued   [N_CH];
  logic [FRM_W-1:0]  accepted [N_CH];
  logic [FRM_W-1:0]  row_end  [N_CH];

  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_idx;
  logic              frame_start, all_issued, can_issue, issue, xfer;

  logic              inflight_q;
  logic [CH_W-1:0]   inflight_ch;
  logic [FRM_W-1:0]  inflight_idx;

  logic [DATA_W-1:0] buf_data [2];
  logic [CH_W-1:0]   buf_ch   [2];
  logic [FRM_W-1:0]  buf_idx  [2];
  logic              buf_wr_ptr, buf_rd_ptr;
  logic [1:0]        buf_cnt;

  assign frame_start = start && (state == ST_IDLE);
  assign wb_valid    = (buf_cnt != 2'd0);
  assign xfer        = wb_valid && wb_ready;
  assign wb_data     = wb_valid ? buf_data[buf_rd_ptr] : '0;
  assign wb_ch       = wb_valid ? buf_ch[buf_rd_ptr]   : '0;
  assign wb_idx      = wb_valid ? buf_idx[buf_rd_ptr] : '0;
  assign row_done    = xfer && (accepted[wb_ch] == row_end[wb_ch]);

  always_comb begin
    all_issued = 1'b1;
    eligible   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (issued[c] != frm_words_q) all_issued = 1'b0;
      eligible[c] = (state == ST_RUN) && !fifo_empty[c] && (issued[c] < frm_words_q);
    end
  end

  // A word leaving the buffer this cycle frees its slot for a new read.
  assign can_issue  = (({1'b0, buf_cnt} + {2'b00, inflight_q}) - {2'b00, xfer}) < 3'd2;
  assign issue      = can_issue && (|eligible);
  assign fifo_rd_en = issue ? grant : '0;

  wb_rr_arbiter #(.N(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_start),
    .issue     (issue),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (all_issued) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!inflight_q && (buf_cnt == 2'd0)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_words_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        issued[c]   <= '0;
        accepted[c] <= '0;
        row_end[c]  <= '0;
      end
    end else if (frame_start) begin
      frm_words_q <= frame_words;
      for (int c = 0; c < N_CH; c++) begin
        issued[c]   <= '0;
        accepted[c] <= '0;
        row_end[c]  <= FRM_W'(ROW_LEN - 1);
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (fifo_rd_en[c]) issued[c] <= issued[c] + FRM_W'(1);
      end
      // row_end tracks the index of the last word of the current row per channel.
      if (xfer) begin
        accepted[wb_ch] <= accepted[wb_ch] + FRM_W'(1);
        if (accepted[wb_ch] == row_end[wb_ch])
          row_end[wb_ch] <= row_end[wb_ch] + FRM_W'(ROW_LEN);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      inflight_ch  <= '0;
      inflight_idx <= '0;
    end else begin
      inflight_q   <= issue;
      inflight_ch  <= grant_idx;
      inflight_idx <= issued[grant_idx];
    end
  end

  // Returned data lands in the 2-entry buffer the cycle after its read enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr_ptr <= 1'b0;
      buf_rd_ptr <= 1'b0;
      buf_cnt    <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        buf_data[e] <= '0;
        buf_ch[e]   <= '0;
        buf_idx[e]  <= '0;
      end
    end else begin
      if (inflight_q) begin
        buf_data[buf_wr_ptr] <= fifo_dout[int'(inflight_ch)*DATA_W +: DATA_W];
        buf_ch[buf_wr_ptr]   <= inflight_ch;
        buf_idx[buf_wr_ptr]  <= inflight_idx;
        buf_wr_ptr           <= ~buf_wr_ptr;
      end
      if (xfer) buf_rd_ptr <= ~buf_rd_ptr;
      buf_cnt <= (buf_cnt + {1'b0, inflight_q}) - {1'b0, xfer};
    end
  end

endmodule

// File: tb/tb_wb_fifo_scheduler.sv
// Directed bench for wb_fifo_scheduler: behavioural FIFO model, per-cycle
// scoreboard/protocol monitor, a table of whole-frame vectors and corner sequences.
module tb_wb_fifo_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  frame_words;
  logic [3:0]   fifo_empty;
  logic [3:0]   fifo_rd_en;
  logic [99:0]  fifo_dout = '0;
  logic         wb_valid;
  logic         wb_ready;
  logic [24:0]  wb_data;
  logic [1:0]   wb_ch;
  logic [15:0]  wb_idx;
  logic         row_done;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_fifo_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_words (frame_words),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_dout   (fifo_dout),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_ch       (wb_ch),
    .wb_idx      (wb_idx),
    .row_done    (row_done),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [24:0] wordOf(input int ch, input int k);
    return 25'((ch << 20) ^ (k * 37 + 5));
  endfunction

  // FIFO model: fill_cnt words written so far, rd_cnt words read; data one cycle after rd_en.
  int   fill_cnt [4];
  int   rd_cnt   [4];
  logic clr_model;

  always_comb begin
    for (int c = 0; c < 4; c++) fifo_empty[c] = (rd_cnt[c] >= fill_cnt[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (clr_model) begin
        rd_cnt[c] <= 0;
      end else if (fifo_rd_en[c]) begin
        rd_cnt[c] <= rd_cnt[c] + 1;
        fifo_dout[c*25 +: 25] <= wordOf(c, rd_cnt[c]);
      end
    end
  end

  // Monitor state
  int          cyc = 0;
  int          xfer_cnt, row_cnt, viol, rr_viol, done_cnt, done_cyc, last_xfer_cyc;
  int          run2, max_run2;
  int          exp_idx  [4];
  int          rd_total [4];
  logic        prev_stall;
  logic [24:0] prev_data;
  logic [1:0]  prev_ch;
  logic [15:0] prev_idx;
  bit          check_rr;
  logic        xfer_now;
  int          viol_now;
  logic        rr_now;

  always_comb begin
    xfer_now = wb_valid && wb_ready;
    viol_now = 0;
    if ($countones(fifo_rd_en) > 1) viol_now++;
    if ((fifo_rd_en & fifo_empty) != 4'b0) viol_now++;
    if (row_done && !xfer_now) viol_now++;
    if (prev_stall && !(wb_valid && wb_data == prev_data && wb_ch == prev_ch && wb_idx == prev_idx))
      viol_now++;
    if (xfer_now) begin
      if (int'(wb_idx) != exp_idx[wb_ch]) viol_now++;
      if (wb_data != wordOf(int'(wb_ch), exp_idx[wb_ch])) viol_now++;
      if (row_done != (((exp_idx[wb_ch] + 1) % 61) == 0)) viol_now++;
    end
    rr_now = check_rr && xfer_now && (int'(wb_ch) != (xfer_cnt % 4));
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_model) begin
      xfer_cnt <= 0; row_cnt <= 0; viol <= 0; rr_viol <= 0; done_cnt <= 0;
      done_cyc <= 0; last_xfer_cyc <= 0; run2 <= 0; max_run2 <= 0; prev_stall <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        exp_idx[c]  <= 0;
        rd_total[c] <= 0;
      end
    end else begin
      prev_stall <= wb_valid && !wb_ready;
      prev_data  <= wb_data;
      prev_ch    <= wb_ch;
      prev_idx   <= wb_idx;
      viol       <= viol + viol_now;
      if (rr_now) rr_viol <= rr_viol + 1;
      if (xfer_now) begin
        xfer_cnt       <= xfer_cnt + 1;
        exp_idx[wb_ch] <= exp_idx[wb_ch] + 1;
        last_xfer_cyc  <= cyc;
      end
      if (row_done) row_cnt <= row_cnt + 1;
      for (int c = 0; c < 4; c++) begin
        if (fifo_rd_en[c]) rd_total[c] <= rd_total[c] + 1;
      end
      if (fifo_rd_en[2]) begin
        run2 <= run2 + 1;
        if (run2 + 1 > max_run2) max_run2 <= run2 + 1;
      end else begin
        run2 <= 0;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] fw);
    frame_words = fw;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic doReset(input bit chk);
    rst       = 1'b1;
    clr_model = 1'b1;
    start     = 1'b0;
    wb_ready  = 1'b1;
    for (int c = 0; c < 4; c++) fill_cnt[c] = 0;
    tick();
    tick();
    if (chk) begin
      checkOutput("rst_rd_en",    int'(fifo_rd_en), 0);
      checkOutput("rst_wb_valid", int'(wb_valid), 0);
      checkOutput("rst_wb_data",  int'(wb_data), 0);
      checkOutput("rst_wb_ch",    int'(wb_ch), 0);
      checkOutput("rst_wb_idx",   int'(wb_idx), 0);
      checkOutput("rst_row_done", int'(row_done), 0);
      checkOutput("rst_busy",     int'(busy), 0);
      checkOutput("rst_done",     int'(done), 0);
    end
    rst = 1'b0;
    tick();
    clr_model = 1'b0;
    tick();
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    ok = 1'b0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (done_cnt != d0) ok = 1'b1;
    end
    checkOutput("done_seen", int'(ok), 1);
  endtask

  task automatic fillAll(input int n);
    for (int c = 0; c < 4; c++) fill_cnt[c] = n;
  endtask

  typedef struct {
    int fill;
    int fw;
    int exp_xfer;
    int exp_rows;
  } vec_t;

  vec_t vecs [3];

  initial begin
    bit ok;
    int n, x0, rd0;

    rst = 1'b1; start = 1'b0; frame_words = '0; wb_ready = 1'b1;
    clr_model = 1'b1; check_rr = 1'b0;
    for (int c = 0; c < 4; c++) fill_cnt[c] = 0;

    vecs[0] = '{fill: 61,  fw: 61,  exp_xfer: 244, exp_rows: 4};
    vecs[1] = '{fill: 122, fw: 122, exp_xfer: 488, exp_rows: 8};
    vecs[2] = '{fill: 183, fw: 61,  exp_xfer: 244, exp_rows: 4};

    doReset(1'b1);

    // Whole-frame vectors with all FIFOs preloaded and a always-ready sink
    for (int v = 0; v < 3; v++) begin
      doReset(1'b0);
      fillAll(vecs[v].fill);
      check_rr = 1'b1;
      applyStimulus(16'(vecs[v].fw));
      waitDone(3000, ok);
      check_rr = 1'b0;
      checkOutput($sformatf("vec%0d_xfers", v), xfer_cnt, vecs[v].exp_xfer);
      checkOutput($sformatf("vec%0d_rows", v), row_cnt, vecs[v].exp_rows);
      checkOutput($sformatf("vec%0d_rr_order", v), rr_viol, 0);
      checkOutput($sformatf("vec%0d_protocol", v), viol, 0);
      for (int c = 0; c < 4; c++)
        checkOutput($sformatf("vec%0d_reads_ch%0d", v, c), rd_total[c], vecs[v].fw);
      n = done_cyc - last_xfer_cyc;
      checkOutput($sformatf("vec%0d_done_latency_2to3", v), int'(n >= 2 && n <= 3), 1);
      checkOutput($sformatf("vec%0d_busy_after", v), int'(busy), 0);
    end

    // Only channel 2 has data: back-to-back reads on it, none elsewhere
    doReset(1'b0);
    fill_cnt[2] = 61;
    applyStimulus(16'd61);
    repeat (80) tick();
    checkOutput("ch2_run_len", max_run2, 61);
    checkOutput("ch0_no_reads", rd_total[0], 0);
    checkOutput("ch1_no_reads", rd_total[1], 0);
    checkOutput("ch3_no_reads", rd_total[3], 0);
    checkOutput("ch2_busy_waiting", int'(busy), 1);
    fillAll(61);
    waitDone(2000, ok);
    checkOutput("ch2_xfers", xfer_cnt, 244);
    checkOutput("ch2_protocol", viol, 0);

    // Sink stalls for 5 cycles mid-stream
    doReset(1'b0);
    fillAll(61);
    applyStimulus(16'd61);
    repeat (20) tick();
    rd0 = rd_total[0] + rd_total[1] + rd_total[2] + rd_total[3];
    x0  = xfer_cnt;
    wb_ready = 1'b0;
    repeat (5) tick();
    checkOutput("stall_no_reads", rd_total[0] + rd_total[1] + rd_total[2] + rd_total[3] - rd0, 0);
    checkOutput("stall_no_xfers", xfer_cnt - x0, 0);
    checkOutput("stall_valid_held", int'(wb_valid), 1);
    wb_ready = 1'b1;
    waitDone(2000, ok);
    checkOutput("stall_xfers", xfer_cnt, 244);
    checkOutput("stall_protocol", viol, 0);

    // Channel 1 runs dry mid-row and is refilled 10 cycles later
    doReset(1'b0);
    fillAll(61);
    fill_cnt[1] = 30;
    applyStimulus(16'd61);
    n = 0;
    while (rd_total[1] < 30 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("ch1_drained", rd_total[1], 30);
    x0 = xfer_cnt;
    repeat (10) tick();
    checkOutput("others_progress", int'((xfer_cnt - x0) >= 8), 1);
    checkOutput("ch1_idle_gap", rd_total[1], 30);
    fill_cnt[1] = 61;
    waitDone(2000, ok);
    checkOutput("refill_xfers", xfer_cnt, 244);
    checkOutput("refill_rows", row_cnt, 4);
    checkOutput("refill_protocol", viol, 0);

    // Reset mid-frame with reads in flight, then a fresh frame from index 0
    doReset(1'b0);
    fillAll(61);
    applyStimulus(16'd61);
    repeat (15) tick();
    checkOutput("pre_rst_busy", int'(busy), 1);
    doReset(1'b1);
    checkOutput("post_rst_idle", int'(busy), 0);
    fillAll(61);
    applyStimulus(16'd61);
    waitDone(2000, ok);
    checkOutput("post_rst_xfers", xfer_cnt, 244);
    checkOutput("post_rst_protocol", viol, 0);

    // start while busy must not relaunch or change frame_words
    doReset(1'b0);
    fillAll(183);
    applyStimulus(16'd61);
    repeat (30) tick();
    applyStimulus(16'd122);
    checkOutput("restart_busy", int'(busy), 1);
    waitDone(3000, ok);
    checkOutput("restart_xfers", xfer_cnt, 244);
    checkOutput("restart_reads_ch0", rd_total[0], 61);
    checkOutput("restart_reads_ch3", rd_total[3], 61);
    checkOutput("restart_protocol", viol, 0);
    repeat (5) tick();
    checkOutput("restart_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_fifo_scheduler.md
WB_FIFO_SCHEDULER -- requirements
Module: wb_fifo_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of conv-output FIFOs served.
REQ-002 SHALL have parameter DATA_W, default 25: FIFO word width.
REQ-003 SHALL have parameter ROW_LEN, default 61: words per output row per channel.
REQ-004 SHALL have parameter FRM_W, default 16: width of the frame word-count.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches frame_words and begins a frame.
- frame_words  in  FRM_W  words per channel per frame; multiple of ROW_LEN, nonzero.
- fifo_empty  in  N_CH  per-FIFO empty flag.
- fifo_rd_en  out  N_CH  per-FIFO read enable; data returns one cycle later.
- fifo_dout  in  N_CH*DATA_W  concatenated FIFO data_out, channel 0 in the LSBs.
- wb_valid  out  1  write-back word valid.
- wb_ready  in  1  write-back sink ready.
- wb_data  out  DATA_W  write-back word.
- wb_ch  out  clog2(N_CH)  source channel of wb_data.
- wb_idx  out  FRM_W  word index of wb_data within its channel's frame.
- row_done  out  1  one-cycle pulse on acceptance of a channel's last word of a row.
- busy  out  1  high from start until DONE.
- done  out  1  one-cycle pulse at frame completion.

Function
REQ-006 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN once every channel's issued count equals frame_words; DRAIN -> DONE once no read is in flight and the output buffer is empty; DONE -> IDLE after one cycle.
REQ-007 SHALL ignore start outside IDLE.
REQ-008 SHALL assert at most one fifo_rd_en bit per cycle, and only for a channel with fifo_empty low in that same cycle and issued count below frame_words.
REQ-009 SHALL grant round-robin among eligible channels, with the pointer moving to the channel after the last granted one; with a single eligible channel it SHALL read that channel back-to-back every cycle.
REQ-010 SHALL capture the selected channel's fifo_dout exactly one cycle after its fifo_rd_en, tagged with channel and index.
REQ-011 SHALL buffer returned data in a 2-entry FIFO-ordered output buffer and SHALL issue a read only when buffer occupancy plus in-flight reads is less than 2, counting an entry accepted this cycle as freed.
REQ-012 SHALL hold wb_valid, wb_data, wb_ch and wb_idx stable while wb_valid is high and wb_ready is low; a transfer occurs when both are high.
REQ-013 SHALL sustain one word per cycle when wb_ready stays high and at least one FIFO is non-empty.
REQ-014 SHALL keep a per-channel issued counter and a per-channel accepted counter, each FRM_W bits, cleared on start.
REQ-015 SHALL keep wb_idx equal to the accepted count of that channel before the transfer.
REQ-016 SHALL pulse row_done with the transfer for which (wb_idx+1) mod ROW_LEN == 0.
REQ-017 SHALL drive busy high in RUN and DRAIN and pulse done in DONE.

Reset
REQ-018 SHALL, on rst assertion and at any point including mid-frame, immediately return to IDLE and clear all counters, the round-robin pointer and the output buffer.
REQ-019 SHALL hold fifo_rd_en, wb_valid, row_done, busy and done at 0 and wb_data, wb_ch and wb_idx at 0 while in reset.
REQ-020 SHALL discard, after reset release, any read return from a read issued before reset.

Structure
REQ-021 SHALL place the FSM state encoding and the ROW_LEN and DATA_W defaults in the shared write-back package.
REQ-022 SHALL implement the round-robin grant as sub-module wb_rr_arbiter (request vector in, one-hot grant out, pointer update on issue).

Verification
REQ-023 SHALL be checked with the following directed scenarios:
- N_CH=4, all FIFOs preloaded with 61 words, frame_words=61, wb_ready=1 -> wb_ch sequence 0,1,2,3,0,...; 244 transfers; 4 row_done pulses; done 2-3 cycles after the last transfer.
- Only channel 2 non-empty -> fifo_rd_en[2] high on consecutive cycles; no rd_en on empty channels.
- wb_ready low for 5 cycles mid-stream -> at most 2 words buffered, no reads issued, outputs stable, no data loss or reordering.
- Channel 1 FIFO empties mid-row, then is refilled 10 cycles later -> other channels continue; channel 1 wb_idx resumes without a gap.
- rst pulsed mid-frame with a read in flight -> wb_valid 0 and state IDLE; a new start yields wb_idx beginning at 0.
- start pulsed while busy -> ignored; frame_words unchanged.
